// File: rtl/audio_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : audio_sample_fifo
// Description : Synchronises I2S bck/lrck into clk, captures the {in_left,
//               in_right} pair once per frame and buffers it in a show-ahead
//               FIFO with valid/ready read side. Optional macro
//               AUDIO_FIFO_OVF_COUNT_EN adds the saturating ovf_count port.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_sample_fifo #(
    parameter int DEPTH      = 8,
    parameter int SETTLE_BCK = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     bck,
    input  logic                     lrck,
    input  logic [15:0]              in_left,
    input  logic [15:0]              in_right,
    input  logic                     enable,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              out_left,
    output logic [15:0]              out_right,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
`ifdef AUDIO_FIFO_OVF_COUNT_EN
    output logic [15:0]              ovf_count,
`endif
    input  logic                     ovf_clr
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [0:0] C_IDLE   = 1'b0;
    localparam logic [0:0] C_ARMED  = 1'b1;
    localparam logic [3:0] C_SETTLE = 4'(SETTLE_BCK);

    logic [2:0]  bck_sync_q, bck_sync_d;
    logic [2:0]  lrck_sync_q, lrck_sync_d;
    logic        bck_rise, lrck_fall;
    logic [0:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        push;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        overflow_q, overflow_d;
    logic [31:0] mem_q [DEPTH];
    logic [31:0] head;
    logic [AW:0] fill;
    logic        full, pop, push_ok, drop;

    // Bit 0/1 are the synchroniser stages, bit 2 is the edge-detect history
    always_comb begin
        bck_sync_d  = {bck_sync_q[1:0], bck};
        lrck_sync_d = {lrck_sync_q[1:0], lrck};
        bck_rise    = bck_sync_q[1] & ~bck_sync_q[2];
        lrck_fall   = ~lrck_sync_q[1] & lrck_sync_q[2];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!enable) begin
            state_d = C_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                C_IDLE: begin
                    if (lrck_fall) begin
                        state_d = C_ARMED;
                        cnt_d   = C_SETTLE;
                    end
                end
                C_ARMED: begin
                    // A new frame start abandons the one being counted
                    if (lrck_fall) begin
                        cnt_d = C_SETTLE;
                    end else if (bck_rise) begin
                        cnt_d = cnt_q - 4'd1;
                        if (cnt_q == 4'd1) state_d = C_IDLE;
                    end
                end
                default: begin
                    state_d = C_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        push = enable && (state_q == C_ARMED) && bck_rise && !lrck_fall && (cnt_q == 4'd1);
    end

    always_comb begin
        fill       = wr_ptr_q - rd_ptr_q;
        full       = (fill == (AW + 1)'(DEPTH));
        out_valid  = (fill != '0);
        pop        = out_valid & out_ready;
        push_ok    = push & (~full | pop);
        drop       = push & full & ~pop;
        wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push_ok};
        rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};
        overflow_d = ovf_clr ? 1'b0 : (overflow_q | drop);
        head       = mem_q[rd_ptr_q[AW-1:0]];
        out_left   = out_valid ? head[31:16] : 16'h0000;
        out_right  = out_valid ? head[15:0]  : 16'h0000;
        level      = fill;
        overflow   = overflow_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bck_sync_q  <= '0;
            lrck_sync_q <= '0;
            state_q     <= C_IDLE;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
        end else begin
            bck_sync_q  <= bck_sync_d;
            lrck_sync_q <= lrck_sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
        end
    end

    // Storage needs no reset: entries are only visible behind valid pointers
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= {in_left, in_right};
    end

`ifdef AUDIO_FIFO_OVF_COUNT_EN
    logic [15:0] ovf_count_q, ovf_count_d;

    always_comb begin
        ovf_count_d = ovf_count_q;
        if (ovf_clr)                            ovf_count_d = 16'h0000;
        else if (drop && ovf_count_q != 16'hFFFF) ovf_count_d = ovf_count_q + 16'd1;
        ovf_count = ovf_count_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ovf_count_q <= 16'h0000;
        else        ovf_count_q <= ovf_count_d;
    end
`endif

endmodule
`default_nettype wire
